// File: rtl/de_stage_sb.sv
// RV32I decode stage: field/immediate decode, write-first register file read, per-register
// busy-counter scoreboard for RAW stalls, and the registered DE latch feeding AGEX.
module de_stage_sb #(
  parameter int unsigned         DBITS    = 32,
  parameter int unsigned         REGNO    = 32,
  parameter int unsigned         SB_CNT_W = 2,
  parameter int unsigned         CANARY_W = 4,
  parameter logic [CANARY_W-1:0] CANARY   = 4'hA,
  localparam int unsigned        FE_W     = 4 * DBITS + CANARY_W,
  localparam int unsigned        DE_W     = 18 + 6 * DBITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FE_W-1:0] fe_bus,
  input  logic            agex_flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [DBITS-1:0] wb_data,
  output logic            stall_to_fe,
  output logic [DE_W-1:0] de_bus,
  output logic            canary_err
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [SB_CNT_W-1:0] CntMax = '1;

  logic [DBITS-1:0]    inst, pc, pcplus, inst_count;
  logic [CANARY_W-1:0] canary;

  assign inst       = fe_bus[FE_W-1 -: DBITS];
  assign pc         = fe_bus[FE_W-1-DBITS -: DBITS];
  assign pcplus     = fe_bus[FE_W-1-2*DBITS -: DBITS];
  assign inst_count = fe_bus[CANARY_W +: DBITS];
  assign canary     = fe_bus[CANARY_W-1:0];

  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       valid;

  assign op       = inst[6:0];
  assign rd       = inst[11:7];
  assign funct3   = inst[14:12];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign funct7b5 = inst[30];
  assign valid    = (inst != '0);

  // Immediate decode
  logic [31:0]      imm32;
  logic [DBITS-1:0] imm;
  logic             use_rs1, use_rs2, wr_reg;

  always_comb begin
    imm32 = '0;
    unique case (op)
      OpLoad, OpOpImm, OpJalr: imm32 = {{20{inst[31]}}, inst[31:20]};
      OpStore:                 imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OpBranch:                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                        inst[11:8], 1'b0};
      OpLui, OpAuipc:          imm32 = {inst[31:12], 12'b0};
      OpJal:                   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                        inst[30:21], 1'b0};
      default:                 imm32 = '0;
    endcase
  end

  assign imm = {{(DBITS-31){imm32[31]}}, imm32[30:0]};

  assign use_rs1 = !(op == OpLui || op == OpAuipc || op == OpJal);
  assign use_rs2 = (op == OpOp || op == OpStore || op == OpBranch);
  assign wr_reg  = (rd != 5'd0) &&
                   (op == OpOp || op == OpOpImm || op == OpLoad || op == OpLui ||
                    op == OpAuipc || op == OpJal || op == OpJalr);

  // Register file with write-first read
  logic [DBITS-1:0] rf_q [REGNO];
  logic [DBITS-1:0] rs1_val, rs2_val;
  logic             wb_rel;

  assign wb_rel = wb_we && (wb_rd != 5'd0);

  always_comb begin
    if (rs1 == 5'd0)                 rs1_val = '0;
    else if (wb_rel && wb_rd == rs1) rs1_val = wb_data;
    else                             rs1_val = rf_q[rs1];
    if (rs2 == 5'd0)                 rs2_val = '0;
    else if (wb_rel && wb_rd == rs2) rs2_val = wb_data;
    else                             rs2_val = rf_q[rs2];
  end

  // Scoreboard: WB release is folded in before the hazard check
  logic [SB_CNT_W-1:0] cnt_q    [REGNO];
  logic [SB_CNT_W-1:0] cnt_post [REGNO];
  logic [SB_CNT_W-1:0] cnt_d    [REGNO];
  logic                raw, sat, hazard, issue;

  always_comb begin
    for (int r = 0; r < REGNO; r++) begin
      cnt_post[r] = cnt_q[r];
      if (wb_rel && wb_rd == 5'(r) && cnt_q[r] != '0) cnt_post[r] = cnt_q[r] - 1'b1;
    end
  end

  assign raw = (use_rs1 && rs1 != 5'd0 && cnt_post[rs1] != '0) ||
               (use_rs2 && rs2 != 5'd0 && cnt_post[rs2] != '0);
  assign sat = wr_reg && (cnt_post[rd] == CntMax);

  assign hazard      = valid && (raw || sat);
  assign stall_to_fe = hazard && !agex_flush;
  assign issue       = valid && !hazard && !agex_flush && wr_reg;

  always_comb begin
    for (int r = 0; r < REGNO; r++) begin
      cnt_d[r] = cnt_post[r];
      if (issue && rd == 5'(r)) cnt_d[r] = cnt_post[r] + 1'b1;
    end
  end

  // DE latch next state; flushed, stalled and empty slots all become zero bubbles
  logic [DE_W-1:0] de_d, de_q;
  logic            canary_err_q;

  always_comb begin
    de_d = '0;
    if (valid && !hazard && !agex_flush) begin
      de_d = {1'b1, op, funct3, funct7b5, rd, wr_reg, rs1_val, rs2_val, imm, pc, pcplus,
              inst_count};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_q         <= '0;
      canary_err_q <= 1'b0;
      for (int r = 0; r < REGNO; r++) begin
        cnt_q[r] <= '0;
        rf_q[r]  <= '0;
      end
    end else begin
      de_q <= de_d;
      for (int r = 0; r < REGNO; r++) cnt_q[r] <= cnt_d[r];
      if (wb_rel) rf_q[wb_rd] <= wb_data;
      if (valid && canary != CANARY) canary_err_q <= 1'b1;
    end
  end

  assign de_bus     = de_q;
  assign canary_err = canary_err_q;

endmodule

// File: tb/tb_de_stage_sb.sv
// Directed bench for de_stage_sb: each step drives one cycle, pushes the expected DE latch to a
// queue, then pops and compares it after the clock edge.
module tb_de_stage_sb;

  logic         clk = 1'b0;
  logic         reset;
  logic [131:0] fe_bus;
  logic         agex_flush;
  logic         wb_we;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         stall_to_fe;
  logic [209:0] de_bus;
  logic         canary_err;

  int           errors = 0;
  int           checks = 0;
  logic [31:0]  model_rf [32];
  logic         exp_can;
  logic [209:0] exp_q [$];
  logic [31:0]  pc_r, ic_r;

  localparam logic [31:0] I_ADDI5 = 32'h0070_0293;  // addi x5,x0,7
  localparam logic [31:0] I_ADD6  = 32'h0052_8333;  // add  x6,x5,x5
  localparam logic [31:0] I_LUI1  = 32'h1234_50B7;  // lui  x1,0x12345
  localparam logic [31:0] I_BEQ   = 32'hFE00_0EE3;  // beq  x0,x0,-4
  localparam logic [31:0] I_SW6   = 32'h0060_2023;  // sw   x6,0(x0)
  localparam logic [31:0] I_ADDI3 = 32'h0010_0193;  // addi x3,x0,1
  localparam logic [31:0] I_ADDI7 = 32'h0010_0393;  // addi x7,x0,1
  localparam logic [31:0] I_ADD8  = 32'h0073_8433;  // add  x8,x7,x7

  always #5 clk = ~clk;

  de_stage_sb dut (
    .clk         (clk),
    .reset       (reset),
    .fe_bus      (fe_bus),
    .agex_flush  (agex_flush),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .stall_to_fe (stall_to_fe),
    .de_bus      (de_bus),
    .canary_err  (canary_err)
  );

  function automatic logic [31:0] rd_model(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wdata);
    if (idx == 5'd0) return 32'd0;
    if (we && wrd == idx) return wdata;
    return model_rf[idx];
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic [31:0] inst,
                     input logic [3:0] can, input logic flush, input logic we,
                     input logic [4:0] wrd, input logic [31:0] wdata, input logic exp_stall,
                     input logic [31:0] exp_imm, input logic exp_wr);
    logic [209:0] exp_bus, got_exp;
    logic         v;
    reset      = rst;
    fe_bus     = {inst, pc_r, pc_r + 32'd4, ic_r, can};
    agex_flush = flush;
    wb_we      = we;
    wb_rd      = wrd;
    wb_data    = wdata;
    #1;
    if (!rst) begin
      checks++;
      assert (stall_to_fe === exp_stall)
      else begin
        errors++;
        $error("FAIL %s stall_to_fe: got %b want %b", tag, stall_to_fe, exp_stall);
      end
    end
    v = (inst != 32'd0) && !flush && !exp_stall && !rst;
    exp_bus = '0;
    if (v) begin
      exp_bus = {1'b1, inst[6:0], inst[14:12], inst[30], inst[11:7], exp_wr,
                 rd_model(inst[19:15], we, wrd, wdata), rd_model(inst[24:20], we, wrd, wdata),
                 exp_imm, pc_r, pc_r + 32'd4, ic_r};
    end
    exp_q.push_back(exp_bus);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      exp_can = 1'b0;
    end else begin
      if (we && wrd != 5'd0) model_rf[wrd] = wdata;
      if (inst != 32'd0 && can != 4'hA) exp_can = 1'b1;
    end
    pc_r = pc_r + 32'd4;
    ic_r = ic_r + 32'd1;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s de_bus: got %h want <scoreboard empty>", tag, de_bus);
    end else begin
      got_exp = exp_q.pop_front();
      assert (de_bus === got_exp)
      else begin
        errors++;
        $error("FAIL %s de_bus: got %h want %h", tag, de_bus, got_exp);
      end
    end
    checks++;
    assert (canary_err === exp_can)
    else begin
      errors++;
      $error("FAIL %s canary_err: got %b want %b", tag, canary_err, exp_can);
    end
  endtask

  initial begin
    pc_r    = 32'h0000_1000;
    ic_r    = 32'd0;
    exp_can = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

    cyc("reset0",   1'b1, 32'd0,   4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    cyc("reset1",   1'b1, 32'd0,   4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    cyc("bubble",   1'b0, 32'd0,   4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    cyc("lui",      1'b0, I_LUI1,  4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'h1234_5000, 1'b1);
    cyc("beq",      1'b0, I_BEQ,   4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);

    // RAW on x5, released by a same-cycle WB
    cyc("addi5",    1'b0, I_ADDI5, 4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd7, 1'b1);
    cyc("add_st0",  1'b0, I_ADD6,  4'hA, 1'b0, 1'b1, 5'd1, 32'h1234_5000, 1'b1, 32'd0, 1'b1);
    cyc("add_st1",  1'b0, I_ADD6,  4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 1'b1);
    cyc("add_rel",  1'b0, I_ADD6,  4'hA, 1'b0, 1'b1, 5'd5, 32'd7, 1'b0, 32'd0, 1'b1);
    cyc("sw_st",    1'b0, I_SW6,   4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0);
    cyc("sw_rel",   1'b0, I_SW6,   4'hA, 1'b0, 1'b1, 5'd6, 32'd14, 1'b0, 32'd0, 1'b0);

    // Flush of a stalled op leaves counters alone
    cyc("addi5b",   1'b0, I_ADDI5, 4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd7, 1'b1);
    cyc("add_fl",   1'b0, I_ADD6,  4'hA, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc("add_st2",  1'b0, I_ADD6,  4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 1'b1);
    cyc("sw_free",  1'b0, I_SW6,   4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    cyc("wb5",      1'b0, 32'd0,   4'hA, 1'b0, 1'b1, 5'd5, 32'd99, 1'b0, 32'd0, 1'b0);
    cyc("addi7_fl", 1'b0, I_ADDI7, 4'hA, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd1, 1'b1);
    cyc("add8",     1'b0, I_ADD8,  4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);

    // Counter saturation on x3
    cyc("addi3_a",  1'b0, I_ADDI3, 4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd1, 1'b1);
    cyc("addi3_b",  1'b0, I_ADDI3, 4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd1, 1'b1);
    cyc("addi3_c",  1'b0, I_ADDI3, 4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd1, 1'b1);
    cyc("addi3_sat",1'b0, I_ADDI3, 4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd1, 1'b1);
    cyc("addi3_wb", 1'b0, I_ADDI3, 4'hA, 1'b0, 1'b1, 5'd3, 32'd5, 1'b0, 32'd1, 1'b1);
    cyc("addi3_s2", 1'b0, I_ADDI3, 4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd1, 1'b1);

    // Canary: ignored on bubbles, sticky on valid, cleared by reset
    cyc("can_bub",  1'b0, 32'd0,   4'h5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    cyc("can_bad",  1'b0, I_BEQ,   4'h5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    cyc("can_keep", 1'b0, I_BEQ,   4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    cyc("can_rst",  1'b1, 32'd0,   4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of a stall
    cyc("addi5c",   1'b0, I_ADDI5, 4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd7, 1'b1);
    cyc("add_st3",  1'b0, I_ADD6,  4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 1'b1);
    cyc("rst_mid",  1'b1, I_ADD6,  4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc("add_post", 1'b0, I_ADD6,  4'hA, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
